// File: rtl/action_ram_arbiter_pkg.sv
// Shared constants and types for the action RAM arbiter: widths, grant encoding
// and the queued config-write payload.
package action_ram_arbiter_pkg;

  localparam int unsigned ACT_LEN    = 25;
  localparam int unsigned ACT_NUM    = 25;
  localparam int unsigned ACTION_W   = ACT_LEN * ACT_NUM;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned WQ_DEPTH   = 4;
  localparam int unsigned WQ_PTR_W   = $clog2(WQ_DEPTH);
  localparam int unsigned WQ_CNT_W   = WQ_PTR_W + 1;
  localparam int unsigned STARVE_MAX = 8;
  localparam int unsigned STARVE_W   = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2,
    GNT_FWR  = 2'd3
  } gnt_e;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [ACTION_W-1:0] data;
  } cfg_wr_t;

  function automatic logic gnt_is_wr(gnt_e g);
    return (g == GNT_WR) || (g == GNT_FWR);
  endfunction

endpackage

// File: rtl/action_ram_arbiter_if.sv
// Lookup, config-write, RAM and status signals of the action RAM arbiter.
// slave is the arbiter's view; master is the surrounding stage (lookup, control plane, RAM).
interface action_ram_arbiter_if;
  import action_ram_arbiter_pkg::*;

  logic                lkp_req_valid;
  logic [ADDR_W-1:0]   lkp_req_addr;
  logic                lkp_req_ready;
  logic [ACTION_W-1:0] action_out;
  logic                action_valid_out;
  logic                cfg_wr_valid;
  logic [ADDR_W-1:0]   cfg_wr_addr;
  logic [ACTION_W-1:0] cfg_wr_data;
  logic                cfg_wr_ready;
  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_we;
  logic [ACTION_W-1:0] ram_wdata;
  logic [ACTION_W-1:0] ram_rdata;
  logic [WQ_CNT_W-1:0] wq_count;

  modport slave (
    input  lkp_req_valid, lkp_req_addr, cfg_wr_valid, cfg_wr_addr, cfg_wr_data, ram_rdata,
    output lkp_req_ready, action_out, action_valid_out, cfg_wr_ready,
           ram_addr, ram_we, ram_wdata, wq_count
  );

  modport master (
    output lkp_req_valid, lkp_req_addr, cfg_wr_valid, cfg_wr_addr, cfg_wr_data, ram_rdata,
    input  lkp_req_ready, action_out, action_valid_out, cfg_wr_ready,
           ram_addr, ram_we, ram_wdata, wq_count
  );

endinterface

// File: rtl/action_wr_fifo.sv
// Synchronous FIFO holding pending config writes; full/empty derive from the
// registered occupancy, so a full FIFO never accepts a push even when popping.
module action_wr_fifo
  import action_ram_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push_valid,
  input  cfg_wr_t             push_data,
  output logic                push_ready_c,
  input  logic                pop,
  output cfg_wr_t             head_c,
  output logic                empty_c,
  output logic [WQ_CNT_W-1:0] count
);

  cfg_wr_t             mem [WQ_DEPTH];
  logic [WQ_PTR_W-1:0] wr_ptr;
  logic [WQ_PTR_W-1:0] rd_ptr;
  logic                push_en;
  logic                pop_en;

  assign push_ready_c = (count != WQ_CNT_W'(WQ_DEPTH));
  assign empty_c      = (count == '0);
  assign head_c       = mem[rd_ptr];
  assign push_en      = push_valid && push_ready_c;
  assign pop_en       = pop && !empty_c;

  // Payload storage carries no reset; only pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + WQ_PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + WQ_PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + WQ_CNT_W'(1);
        2'b01:   count <= count - WQ_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/action_ram_arbiter.sv
// Arbitrates the single-port action RAM between lookup reads (priority) and queued
// config writes, with a starvation counter that forces a write slot.
module action_ram_arbiter
  import action_ram_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  action_ram_arbiter_if.slave  bus
);

  gnt_e                gnt_c;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_cnt_nxt;
  logic                action_valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   ram_addr_c;
  logic                wq_empty_c;
  logic                wq_ready_c;
  logic [WQ_CNT_W-1:0] wq_count;
  cfg_wr_t             wq_head_c;
  cfg_wr_t             push_data;

  assign push_data.addr = bus.cfg_wr_addr;
  assign push_data.data = bus.cfg_wr_data;

  action_wr_fifo u_wr_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (bus.cfg_wr_valid),
    .push_data    (push_data),
    .push_ready_c (wq_ready_c),
    .pop          (gnt_is_wr(gnt_c)),
    .head_c       (wq_head_c),
    .empty_c      (wq_empty_c),
    .count        (wq_count)
  );

  // Grant decode and starvation-counter next state.
  always_comb begin
    gnt_c          = GNT_IDLE;
    starve_cnt_nxt = starve_cnt;
    ram_addr_c     = addr_q;

    if ((starve_cnt == STARVE_W'(STARVE_MAX)) && !wq_empty_c) begin
      gnt_c = GNT_FWR;
    end else if (bus.lkp_req_valid) begin
      gnt_c = GNT_RD;
    end else if (!wq_empty_c) begin
      gnt_c = GNT_WR;
    end

    if (gnt_c == GNT_RD) begin
      ram_addr_c = bus.lkp_req_addr;
    end else if (gnt_is_wr(gnt_c)) begin
      ram_addr_c = wq_head_c.addr;
    end

    if (gnt_is_wr(gnt_c) || wq_empty_c) begin
      starve_cnt_nxt = '0;
    end else if ((gnt_c == GNT_RD) && (starve_cnt != STARVE_W'(STARVE_MAX))) begin
      starve_cnt_nxt = starve_cnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt     <= '0;
      action_valid_q <= 1'b0;
      addr_q         <= '0;
    end else begin
      starve_cnt     <= starve_cnt_nxt;
      action_valid_q <= (gnt_c == GNT_RD);
      addr_q         <= ram_addr_c;
    end
  end

  assign bus.lkp_req_ready    = (gnt_c != GNT_FWR);
  assign bus.ram_we           = gnt_is_wr(gnt_c);
  assign bus.ram_addr         = ram_addr_c;
  assign bus.ram_wdata        = gnt_is_wr(gnt_c) ? wq_head_c.data : '0;
  assign bus.cfg_wr_ready     = wq_ready_c;
  assign bus.wq_count         = wq_count;
  assign bus.action_out       = bus.ram_rdata;
  assign bus.action_valid_out = action_valid_q;

endmodule

// File: tb/tb_action_ram_arbiter.sv
// Directed bench for action_ram_arbiter with a behavioural 1-cycle-latency RAM.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_action_ram_arbiter;
  import action_ram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  action_ram_arbiter_if bus ();

  action_ram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [ACTION_W-1:0] pat(input int s);
    logic [ACT_LEN-1:0] w;
    w = ACT_LEN'(s);
    return {ACT_NUM{w}};
  endfunction

  // Read-before-write RAM, preloaded with pat(3*i+1) on the first clock.
  logic [ACTION_W-1:0] mem [16];
  logic                loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= pat(3 * i + 1);
      loaded <= 1'b1;
    end else begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [ACTION_W-1:0] obs,
                      input logic [ACTION_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [ACT_LEN-1:0]  w6_word;
  logic [ACTION_W-1:0] w6;
  logic [ACTION_W-1:0] ones;

  initial begin
    w6_word = {4'b0001, 5'd6, 5'd7, 5'd0, 6'd0};
    w6      = {ACT_NUM{w6_word}};
    ones    = '1;
    rst = 1'b1;
    bus.lkp_req_valid = 1'b0;
    bus.lkp_req_addr  = '0;
    bus.cfg_wr_valid  = 1'b0;
    bus.cfg_wr_addr   = '0;
    bus.cfg_wr_data   = '0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_wq_count", 32'(bus.wq_count), 32'd0);
    chk("rst_valid", 32'(bus.action_valid_out), 32'd0);
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chkw("rst_wdata", bus.ram_wdata, '0);
    chk("rst_cfg_ready", 32'(bus.cfg_wr_ready), 32'd1);
    chk("rst_lkp_ready", 32'(bus.lkp_req_ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    // 1: back-to-back reads of 3,5,7
    @(negedge clk); bus.lkp_req_valid = 1'b1; bus.lkp_req_addr = 4'd3; #1;
    chk("t1_ready3", 32'(bus.lkp_req_ready), 32'd1);
    chk("t1_addr3", 32'(bus.ram_addr), 32'd3);
    @(negedge clk); bus.lkp_req_addr = 4'd5; #1;
    chk("t1_valid3", 32'(bus.action_valid_out), 32'd1);
    chkw("t1_data3", bus.action_out, pat(10));
    chk("t1_ready5", 32'(bus.lkp_req_ready), 32'd1);
    chk("t1_addr5", 32'(bus.ram_addr), 32'd5);
    @(negedge clk); bus.lkp_req_addr = 4'd7; #1;
    chk("t1_valid5", 32'(bus.action_valid_out), 32'd1);
    chkw("t1_data5", bus.action_out, pat(16));
    @(negedge clk); bus.lkp_req_valid = 1'b0; #1;
    chk("t1_valid7", 32'(bus.action_valid_out), 32'd1);
    chkw("t1_data7", bus.action_out, pat(22));
    chk("t1_idle_addr_hold", 32'(bus.ram_addr), 32'd7);
    chk("t1_ready_idle", 32'(bus.lkp_req_ready), 32'd1);
    @(negedge clk); #1;
    chk("t1_valid_drop", 32'(bus.action_valid_out), 32'd0);

    // 2: idle write to 6, then read it back
    @(negedge clk);
    bus.cfg_wr_valid = 1'b1; bus.cfg_wr_addr = 4'd6; bus.cfg_wr_data = w6; #1;
    chk("t2_cfg_ready", 32'(bus.cfg_wr_ready), 32'd1);
    chk("t2_we_push", 32'(bus.ram_we), 32'd0);
    @(negedge clk); bus.cfg_wr_valid = 1'b0; #1;
    chk("t2_we", 32'(bus.ram_we), 32'd1);
    chk("t2_addr", 32'(bus.ram_addr), 32'd6);
    chkw("t2_wdata", bus.ram_wdata, w6);
    chk("t2_count1", 32'(bus.wq_count), 32'd1);
    @(negedge clk); bus.lkp_req_valid = 1'b1; bus.lkp_req_addr = 4'd6; #1;
    chk("t2_we_done", 32'(bus.ram_we), 32'd0);
    chk("t2_count0", 32'(bus.wq_count), 32'd0);
    chk("t2_valid_after_wr", 32'(bus.action_valid_out), 32'd0);
    @(negedge clk); bus.lkp_req_valid = 1'b0; #1;
    chk("t2_rd_valid", 32'(bus.action_valid_out), 32'd1);
    chkw("t2_rd_data", bus.action_out, w6);

    // 3: starvation with one pending write and continuous lookups
    @(negedge clk);
    bus.lkp_req_valid = 1'b1; bus.lkp_req_addr = 4'd1;
    bus.cfg_wr_valid = 1'b1; bus.cfg_wr_addr = 4'd9; bus.cfg_wr_data = pat(32'h0AAAAAA); #1;
    chk("t3_ready_push", 32'(bus.lkp_req_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus.cfg_wr_valid = 1'b0; bus.lkp_req_addr = 4'(i); #1;
      chk($sformatf("t3_ready_rd%0d", i), 32'(bus.lkp_req_ready), 32'd1);
      chk($sformatf("t3_we_rd%0d", i), 32'(bus.ram_we), 32'd0);
    end
    @(negedge clk); #1;
    chk("t3_force_ready", 32'(bus.lkp_req_ready), 32'd0);
    chk("t3_force_we", 32'(bus.ram_we), 32'd1);
    chk("t3_force_addr", 32'(bus.ram_addr), 32'd9);
    chkw("t3_force_wdata", bus.ram_wdata, pat(32'h0AAAAAA));
    @(negedge clk); #1;
    chk("t3_resume_ready", 32'(bus.lkp_req_ready), 32'd1);
    chk("t3_resume_we", 32'(bus.ram_we), 32'd0);
    chk("t3_resume_count", 32'(bus.wq_count), 32'd0);
    chk("t3_valid_after_force", 32'(bus.action_valid_out), 32'd0);
    @(negedge clk); bus.lkp_req_valid = 1'b0;

    // 4: fill the FIFO under continuous reads
    bus.lkp_req_valid = 1'b1; bus.lkp_req_addr = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.cfg_wr_valid = 1'b1; bus.cfg_wr_addr = 4'(10 + k); bus.cfg_wr_data = pat(100 + k); #1;
      chk($sformatf("t4_cfg_ready%0d", k), 32'(bus.cfg_wr_ready), 32'd1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.cfg_wr_addr = 4'd14; bus.cfg_wr_data = pat(104); #1;
      chk($sformatf("t4_full_ready%0d", k), 32'(bus.cfg_wr_ready), 32'd0);
      chk($sformatf("t4_full_count%0d", k), 32'(bus.wq_count), 32'd4);
      chk($sformatf("t4_lkp_ready%0d", k), 32'(bus.lkp_req_ready), 32'd1);
    end
    @(negedge clk); #1;
    chk("t4_force_ready", 32'(bus.lkp_req_ready), 32'd0);
    chk("t4_force_we", 32'(bus.ram_we), 32'd1);
    chk("t4_force_addr", 32'(bus.ram_addr), 32'd10);
    chkw("t4_force_wdata", bus.ram_wdata, pat(100));
    chk("t4_no_passthru", 32'(bus.cfg_wr_ready), 32'd0);
    @(negedge clk); #1;
    chk("t4_ready_after_pop", 32'(bus.cfg_wr_ready), 32'd1);
    chk("t4_count3", 32'(bus.wq_count), 32'd3);
    chk("t4_we_rd", 32'(bus.ram_we), 32'd0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk); bus.cfg_wr_valid = 1'b0; bus.lkp_req_valid = 1'b0; #1;
      if (k == 1) chk("t4_count4", 32'(bus.wq_count), 32'd4);
      chk($sformatf("t4_drain_we%0d", k), 32'(bus.ram_we), 32'd1);
      chk($sformatf("t4_drain_addr%0d", k), 32'(bus.ram_addr), 32'(10 + k));
      chkw($sformatf("t4_drain_wdata%0d", k), bus.ram_wdata, pat(100 + k));
    end
    @(negedge clk); #1;
    chk("t4_drained_we", 32'(bus.ram_we), 32'd0);
    chk("t4_drained_count", 32'(bus.wq_count), 32'd0);

    // 5: read-after-write to addr 2, no bypass
    @(negedge clk);
    bus.cfg_wr_valid = 1'b1; bus.cfg_wr_addr = 4'd2; bus.cfg_wr_data = ones;
    bus.lkp_req_valid = 1'b1; bus.lkp_req_addr = 4'd2; #1;
    chk("t5_we0", 32'(bus.ram_we), 32'd0);
    chk("t5_addr0", 32'(bus.ram_addr), 32'd2);
    @(negedge clk); bus.cfg_wr_valid = 1'b0; #1;
    chk("t5_valid1", 32'(bus.action_valid_out), 32'd1);
    chkw("t5_old1", bus.action_out, pat(7));
    chk("t5_we1", 32'(bus.ram_we), 32'd0);
    chk("t5_count1", 32'(bus.wq_count), 32'd1);
    @(negedge clk); bus.lkp_req_valid = 1'b0; #1;
    chkw("t5_old2", bus.action_out, pat(7));
    chk("t5_we2", 32'(bus.ram_we), 32'd1);
    chk("t5_addr2", 32'(bus.ram_addr), 32'd2);
    @(negedge clk); bus.lkp_req_valid = 1'b1; bus.lkp_req_addr = 4'd2; #1;
    chk("t5_valid3", 32'(bus.action_valid_out), 32'd0);
    @(negedge clk); bus.lkp_req_valid = 1'b0; #1;
    chk("t5_valid4", 32'(bus.action_valid_out), 32'd1);
    chkw("t5_new4", bus.action_out, ones);

    // 6: reset with three writes queued
    bus.lkp_req_valid = 1'b1; bus.lkp_req_addr = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.cfg_wr_valid = 1'b1; bus.cfg_wr_addr = 4'd15; bus.cfg_wr_data = pat(200 + k);
    end
    @(negedge clk); bus.cfg_wr_valid = 1'b0; bus.lkp_req_valid = 1'b0; rst = 1'b1; #1;
    chk("t6_count3", 32'(bus.wq_count), 32'd3);
    @(negedge clk); rst = 1'b0; #1;
    chk("t6_count0", 32'(bus.wq_count), 32'd0);
    chk("t6_valid", 32'(bus.action_valid_out), 32'd0);
    chk("t6_cfg_ready", 32'(bus.cfg_wr_ready), 32'd1);
    chk("t6_we", 32'(bus.ram_we), 32'd0);
    @(negedge clk); #1;
    chk("t6_we_next", 32'(bus.ram_we), 32'd0);
    chk("t6_count_next", 32'(bus.wq_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
